// File: rtl/muldiv_pkg.sv
// Shared mult/div op codes and sequencer state encoding for the execute stage.
package muldiv_pkg;

  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// One shift-add multiply or restoring-divide iteration on a 2*LEN accumulator.
module muldiv_iter_core #(
  parameter int LEN = 32
) (
  input  logic               i_mode_div,
  input  logic [2*LEN-1:0]   i_acc,
  input  logic [LEN-1:0]     i_opnd,
  output logic [2*LEN-1:0]   o_acc,
  output logic               o_qbit
);

  logic [LEN:0]   w_sum;
  logic [LEN:0]   w_trial;
  logic           w_ge;
  logic [LEN-1:0] w_diff;

  // Multiply: conditional add into upper half then shift right.
  // Divide: shift {rem,quot} left, trial-subtract divisor from the widened remainder.
  always_comb begin
    w_sum   = {1'b0, i_acc[2*LEN-1:LEN]} + {1'b0, i_opnd};
    w_trial = {i_acc[2*LEN-1:LEN], i_acc[LEN-1]};
    w_ge    = (w_trial >= {1'b0, i_opnd});
    // True difference is below 2^LEN whenever w_ge holds, so modular LEN-bit subtraction suffices.
    w_diff  = {i_acc[2*LEN-2:LEN], i_acc[LEN-1]} - i_opnd;
    o_qbit  = 1'b0;
    o_acc   = '0;
    if (i_mode_div) begin
      o_qbit = w_ge;
      o_acc  = {(w_ge ? w_diff : {i_acc[2*LEN-2:LEN], i_acc[LEN-1]}), i_acc[LEN-2:0], w_ge};
    end else if (i_acc[0]) begin
      o_acc = {w_sum, i_acc[LEN-1:1]};
    end else begin
      o_acc = {1'b0, i_acc[2*LEN-1:LEN], i_acc[LEN-1:1]};
    end
  end

endmodule

// File: rtl/execute_muldiv_ctrl.sv
// Execute-stage multiply/divide sequencer: FSM, iteration counter, sign fixup, HI/LO.
module execute_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int LEN      = 32,
  parameter int NB_MD_OP = 3,
  parameter int NB_COUNT = 6
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic [NB_MD_OP-1:0] i_op,
  input  logic [LEN-1:0]      i_dato1,
  input  logic [LEN-1:0]      i_dato2,
  input  logic                i_flush,
  output logic                o_stall,
  output logic                o_done,
  output logic                o_div_by_zero,
  output logic [LEN-1:0]      o_hi,
  output logic [LEN-1:0]      o_lo
);

  md_state_e             r_state;
  logic [NB_COUNT-1:0]   r_count;
  logic [2*LEN-1:0]      r_acc;
  logic [LEN-1:0]        r_opnd;
  logic                  r_is_div;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic                  r_dz;
  logic [LEN-1:0]        r_hi;
  logic [LEN-1:0]        r_lo;

  logic                  w_start;
  logic                  w_div;
  logic                  w_s1;
  logic                  w_s2;
  logic [LEN-1:0]        w_mag1;
  logic [LEN-1:0]        w_mag2;
  logic [2*LEN-1:0]      w_acc_nxt;
  logic                  w_qbit;
  logic [LEN-1:0]        w_hi_fix;
  logic [LEN-1:0]        w_lo_fix;
  logic [2*LEN-1:0]      w_prod;

  // Start decode and operand magnitudes/signs.
  always_comb begin
    w_start = (r_state == ST_IDLE) && i_valid &&
              (i_op == MD_MULT || i_op == MD_MULTU || i_op == MD_DIV || i_op == MD_DIVU);
    w_div   = (i_op == MD_DIV) || (i_op == MD_DIVU);
    w_s1    = ((i_op == MD_MULT) || (i_op == MD_DIV)) && i_dato1[LEN-1];
    w_s2    = ((i_op == MD_MULT) || (i_op == MD_DIV)) && i_dato2[LEN-1];
    w_mag1  = w_s1 ? -i_dato1 : i_dato1;
    w_mag2  = w_s2 ? -i_dato2 : i_dato2;
  end

  muldiv_iter_core #(.LEN(LEN)) u_iter (
    .i_mode_div (r_is_div),
    .i_acc      (r_acc),
    .i_opnd     (r_opnd),
    .o_acc      (w_acc_nxt),
    .o_qbit     (w_qbit)
  );

  // Sign fixup of the finished magnitude result into HI/LO form.
  // A zero divisor leaves rem = |dato1| after LEN steps, so the remainder fixup restores dato1.
  always_comb begin
    w_prod   = r_neg_q ? -r_acc : r_acc;
    w_hi_fix = w_prod[2*LEN-1:LEN];
    w_lo_fix = w_prod[LEN-1:0];
    if (r_is_div) begin
      w_hi_fix = r_neg_r ? -r_acc[2*LEN-1:LEN] : r_acc[2*LEN-1:LEN];
      w_lo_fix = r_dz ? '1 : (r_neg_q ? -r_acc[LEN-1:0] : r_acc[LEN-1:0]);
    end
  end

  // Sequencer FSM with counter, latched operands and HI/LO registers; flush wins over everything.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (i_flush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state  <= ST_BUSY;
            r_count  <= '0;
            r_is_div <= w_div;
            r_neg_q  <= w_s1 ^ w_s2;
            r_neg_r  <= w_s1;
            r_dz     <= w_div && (i_dato2 == '0);
            r_acc    <= w_div ? {{LEN{1'b0}}, w_mag1} : {{LEN{1'b0}}, w_mag2};
            r_opnd   <= w_div ? w_mag2 : w_mag1;
          end else if (i_valid && i_op == MD_MTHI) begin
            r_hi <= i_dato1;
          end else if (i_valid && i_op == MD_MTLO) begin
            r_lo <= i_dato1;
          end
        end
        ST_BUSY: begin
          r_acc   <= w_acc_nxt;
          r_count <= r_count + NB_COUNT'(1);
          if (r_count == NB_COUNT'(LEN - 1)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_hi    <= w_hi_fix;
          r_lo    <= w_lo_fix;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stall/done status from the state register and start decode.
  always_comb begin
    o_stall       = w_start || (r_state == ST_BUSY);
    o_done        = (r_state == ST_DONE) && !i_flush;
    o_div_by_zero = o_done && r_dz;
    o_hi          = r_hi;
    o_lo          = r_lo;
  end

endmodule

// File: doc/execute_muldiv_ctrl.md
Name: execute_muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer beside the ALU in the execute stage of the MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX control bundle and runs iterative shift-add multiply or restoring divide, one bit per cycle.
- Holds the instruction in EX by driving a stall to the hazard/pipeline control, and owns the architectural HI/LO registers read by MFHI/MFLO.

Parameters:
- LEN, 32, operand/HI/LO width; iteration count equals LEN.
- NB_MD_OP, 3, width of the operation code.
- NB_COUNT, 6, iteration counter width; must satisfy 2^NB_COUNT > LEN.

Ports:
- i_clk, input, 1, pipeline clock; all state changes on the rising edge.
- i_rst, input, 1, asynchronous active-low reset.
- i_valid, input, 1, the EX instruction carries a mult/div op (qualifies i_op).
- i_op, input, NB_MD_OP, 000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 treated as NONE.
- i_dato1, input, LEN, rs operand (dividend / multiplicand / MTxx source).
- i_dato2, input, LEN, rt operand (divisor / multiplier).
- i_flush, input, 1, abort the current operation (branch/exception flush).
- o_stall, output, 1, freeze IF/ID/EX; the instruction stays in EX.
- o_done, output, 1, one-cycle pulse in the DONE state.
- o_div_by_zero, output, 1, pulse concurrent with o_done when a DIV/DIVU had a zero divisor.
- o_hi, output, LEN, registered HI.
- o_lo, output, LEN, registered LO.

Behaviour:
- Reset (i_rst=0, async): state IDLE, counter 0, o_hi=o_lo=0, internal operands 0. Outputs are then o_stall=0, o_done=0, o_div_by_zero=0. Reset mid-operation discards the operation with no HI/LO write.
- States are IDLE, BUSY and DONE.
- start = IDLE & i_valid & op in {MULT, MULTU, DIV, DIVU}.
- o_stall = start | (state==BUSY). It is combinational and low in DONE.
- IDLE, on start at the edge ending cycle T:
  - Latch |dato1| and |dato2|. Signed ops take the two's-complement magnitude; unsigned ops take the raw value.
  - Latch the result-sign flags. Product and quotient sign = s1^s2; remainder sign = s1.
  - Clear the accumulator, set counter=0, go to BUSY.
- IDLE, MTHI/MTLO with i_valid: o_hi or o_lo <= i_dato1 at the next edge; no stall, state stays IDLE.
- BUSY: one iteration per cycle at cycles T+1..T+LEN.
  - Multiply: if the multiplier LSB is 1, add the multiplicand to the upper half of a 2*LEN accumulator, then shift right 1.
  - Divide: shift {rem,quot} left 1, trial-subtract the divisor from rem; if there is no borrow, keep the difference and set the quotient LSB.
  - At counter==LEN-1, go to DONE.
- DONE, cycle T+LEN+1: o_done=1. Sign fixup is applied, then HI/LO are written at the edge ending DONE, and the state returns to IDLE.
  - Multiply: {HI,LO} = signed/unsigned 2*LEN product.
  - Divide: LO = quotient, HI = remainder.
- Timing summary: stall covers LEN+1 cycles (T..T+LEN). The instruction advances out of EX at the end of DONE, and HI/LO are valid from T+LEN+2.
- i_valid/i_op are ignored while BUSY or DONE. The held instruction cannot restart.
- Divide by zero: HI = original i_dato1, LO = {LEN{1'b1}} regardless of signedness; o_div_by_zero=1 in DONE.
- Signed DIV of INT_MIN by -1 gives LO=0x80000000, HI=0 (natural wrap); no flag.
- i_flush has priority over every transition: any state goes to IDLE at the next edge, with no HI/LO write and no o_done. A start in the same cycle as i_flush is not accepted.
- An MTxx in the same cycle as i_flush is dropped.

Decomposition:
- Shared package muldiv_pkg holds the op-code localparams (MD_NONE..MD_MTLO) and the state encoding (ST_IDLE, ST_BUSY, ST_DONE). The execute-stage control decoder uses it too.
- One sub-module, muldiv_iter_core, is natural. It is the combinational single-iteration step: inputs are mode, accumulator and operand; outputs are the next accumulator and quotient bit.
- execute_muldiv_ctrl keeps the FSM, counter, sign fixup and HI/LO.

Test Plan:
- MULTU 0xFFFFFFFF × 0x2 -> o_stall high 33 cycles; o_done at T+33; HI=0x00000001, LO=0xFFFFFFFE.
- MULT -3 × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 -> o_div_by_zero pulse with o_done; HI=100, LO=0xFFFFFFFF.
- MTHI 0x1234 then MTLO 0xABCD on back-to-back cycles -> no stall; o_hi=0x1234, o_lo=0xABCD one edge after each.
- Start DIVU 50/5, assert i_flush at BUSY cycle 10 -> IDLE next edge; o_stall low; HI/LO keep prior values; no o_done.
- Start MULT, drop i_rst low at BUSY cycle 5 -> immediate IDLE with o_hi=o_lo=0. After release, MULTU 6×7 -> LO=42, HI=0.
